// File: rtl/imu_serial_scheduler_pkg.sv
// Shared FSM encoding and default geometry for the IMU serial scheduler.
package imu_serial_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_NUM_CH     = 6;
    localparam int DEF_DATA_W     = 16;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_CH_W       = 3;

endpackage

// File: rtl/imu_serial_scheduler_if.sv
// Sample-source request bus and serial output bundle of the IMU scheduler.
interface imu_serial_scheduler_if
    import imu_serial_scheduler_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CH_W   = DEF_CH_W
);
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*DATA_W-1:0] data_in;
    logic [NUM_CH-1:0]        ack;
    logic                     so;
    logic                     so_valid;
    logic                     frame_start;
    logic [CH_W-1:0]          ch_id;
    logic                     busy;

    modport master (
        output req, data_in,
        input  ack, so, so_valid, frame_start, ch_id, busy
    );

    modport slave (
        input  req, data_in,
        output ack, so, so_valid, frame_start, ch_id, busy
    );
endinterface

// File: rtl/imu_serial_scheduler_piso_shift_core.sv
// Purpose: parallel-in/serial-out shifter, MSB first, zero fill.
// Latency: loaded word's MSB appears the cycle after load.
// Backpressure: none; shifts whenever shift_en is high.
module piso_shift_core
    import imu_serial_scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic              sout
);
    logic [DATA_W-1:0] shift_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= din;
        end else if (shift_en) begin
            shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
        end
    end

    // Zero fill leaves the register empty after a word, so sout idles low.
    assign sout = shift_reg[DATA_W-1];

endmodule

// File: rtl/imu_serial_scheduler.sv
// Purpose: round-robin share of one serial shifter among NUM_CH sample sources.
// Latency: grant edge -> ack + MSB next cycle; word period 1+DATA_W+GAP_CYCLES.
// Backpressure: req is level, sampled only in IDLE; requester drops it after ack.
module imu_serial_scheduler
    import imu_serial_scheduler_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int CH_W       = DEF_CH_W
) (
    input  logic clk,
    input  logic rst_n,
    imu_serial_scheduler_if.slave bus
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int GAP_W = 4;

    state_t            state;
    state_t            state_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   grant;
    logic [DATA_W-1:0] grant_dat;
    logic              load;
    logic              shift_en;
    logic              bit_last;
    logic              gap_last;

    // First set request at or above the pointer, wrapping modulo NUM_CH.
    function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] r,
                                                input logic [CH_W-1:0]   p);
        logic [CH_W-1:0] g;
        int              idx;
        g = p;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NUM_CH;
            if (r[idx]) g = idx[CH_W-1:0];
        end
        return g;
    endfunction

    assign grant     = rr_pick(bus.req, rr_ptr);
    assign grant_dat = bus.data_in[int'(grant)*DATA_W +: DATA_W];
    assign bit_last  = (int'(bit_cnt) == DATA_W - 1);
    assign gap_last  = (int'(gap_cnt) == GAP_CYCLES - 1);

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        shift_en = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (|bus.req) begin
                    load    = 1'b1;
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (bit_last) state_n = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            end
            ST_GAP: begin
                if (gap_last) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            rr_ptr          <= '0;
            bus.ack         <= '0;
            bus.ch_id       <= '0;
            bus.so_valid    <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.busy        <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= (shift_en && !bit_last) ? bit_cnt + CNT_W'(1) : '0;
            gap_cnt <= (state == ST_GAP && !gap_last) ? gap_cnt + GAP_W'(1) : '0;
            bus.ack <= load ? (NUM_CH'(1) << grant) : '0;
            if (load) begin
                bus.ch_id <= grant;
                rr_ptr    <= (int'(grant) == NUM_CH - 1) ? '0 : grant + CH_W'(1);
            end
            // Flag outputs follow the next state so they line up with the shifter.
            bus.so_valid    <= (state_n == ST_SHIFT);
            bus.frame_start <= load;
            bus.busy        <= (state_n != ST_IDLE);
        end
    end

    piso_shift_core #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .shift_en (shift_en),
        .din      (grant_dat),
        .sout     (bus.so)
    );

endmodule

// File: tb/tb_imu_serial_scheduler.sv
// Bench: two schedulers (gap 2 and gap 0) against a word-schedule model.
module tb_imu_serial_scheduler;
    localparam int NCH   = 6;
    localparam int DW    = 16;
    localparam int CHW   = 3;
    localparam int OUT_W = NCH + 4 + CHW;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NCH-1:0]    req_s [2];
    logic [NCH*DW-1:0] dat_s;

    imu_serial_scheduler_if #(.NUM_CH(NCH), .DATA_W(DW), .CH_W(CHW)) if0 ();
    imu_serial_scheduler_if #(.NUM_CH(NCH), .DATA_W(DW), .CH_W(CHW)) if1 ();

    assign if0.req     = req_s[0];
    assign if0.data_in = dat_s;
    assign if1.req     = req_s[1];
    assign if1.data_in = dat_s;

    imu_serial_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .GAP_CYCLES(2), .CH_W(CHW)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    imu_serial_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .GAP_CYCLES(0), .CH_W(CHW)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;
    bit release_now = 0;
    int gap_of [2] = '{2, 0};

    // Model: each word occupies cycles start..start+DW-1 on the wire, then the gap.
    int             m_ptr   [2];
    int             m_start [2];
    int             m_gch   [2];
    bit             m_has   [2];
    logic [DW-1:0]  m_word  [2];

    int acks0[$], acks1[$], fs0[$], fs1[$], words0[$], words1[$];
    logic [DW-1:0]  ob_bits  [2];
    int             ob_n     [2];
    int             busy_cnt [2];
    int             nz_cnt   [2];
    logic [NCH-1:0] ack_now  [2];

    function automatic logic [OUT_W-1:0] expect_out(int k);
        logic [NCH-1:0] a;
        logic so, sv, fs, b;
        int d;
        a = '0; so = 1'b0; sv = 1'b0; fs = 1'b0; b = 1'b0;
        d = cyc - m_start[k];
        if (m_has[k]) begin
            if (d == 0) begin
                a[m_gch[k]] = 1'b1;
                fs = 1'b1;
            end
            if (d >= 0 && d < DW) begin
                sv = 1'b1;
                so = m_word[k][DW-1-d];
            end
            if (d >= 0 && d < DW + gap_of[k]) b = 1'b1;
        end
        return {a, so, sv, fs, CHW'(m_gch[k]), b};
    endfunction

    function automatic logic [OUT_W-1:0] actual_out(int k);
        if (k == 0)
            return {if0.ack, if0.so, if0.so_valid, if0.frame_start, if0.ch_id, if0.busy};
        return {if1.ack, if1.so, if1.so_valid, if1.frame_start, if1.ch_id, if1.busy};
    endfunction

    function automatic bit model_idle(int k);
        return !m_has[k] || (cyc - m_start[k] >= DW + gap_of[k]);
    endfunction

    function automatic int oh_idx(logic [NCH-1:0] v);
        int idx, n;
        idx = -1; n = 0;
        for (int i = 0; i < NCH; i++) if (v[i]) begin idx = i; n++; end
        return (n == 1) ? idx : -1;
    endfunction

    function automatic int qa(int q[$], int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_obs();
        acks0.delete(); acks1.delete(); fs0.delete(); fs1.delete();
        words0.delete(); words1.delete();
        for (int k = 0; k < 2; k++) begin
            ob_bits[k] = '0; ob_n[k] = 0; busy_cnt[k] = 0; nz_cnt[k] = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_has[k] = 1'b0; m_ptr[k] = 0; m_gch[k] = 0; m_start[k] = 0;
        end
    endtask

    task automatic observe(int k, logic [OUT_W-1:0] o);
        logic [NCH-1:0] a;
        a = o[OUT_W-1 -: NCH];
        if (a != '0) begin
            if (k == 0) acks0.push_back(oh_idx(a)); else acks1.push_back(oh_idx(a));
        end
        if (o[CHW+1]) begin
            if (k == 0) fs0.push_back(cyc); else fs1.push_back(cyc);
            ob_n[k] = 0;
        end
        if (o[CHW+2]) begin
            ob_bits[k] = {ob_bits[k][DW-2:0], o[CHW+3]};
            ob_n[k]++;
            if (ob_n[k] == DW) begin
                if (k == 0) words0.push_back(int'(ob_bits[k])); else words1.push_back(int'(ob_bits[k]));
                ob_n[k] = 0;
            end
        end
        if (o[0]) busy_cnt[k]++;
        if (a != '0 || o[CHW+3:CHW+1] != 3'b000) nz_cnt[k]++;
    endtask

    task automatic stim();
        for (int k = 0; k < 2; k++) begin
            if (mode != 1) req_s[k] = req_s[k] & ~ack_now[k];
            if (mode == 2) begin
                for (int i = 0; i < NCH; i++)
                    if (!req_s[k][i] && $urandom_range(7) == 0) req_s[k][i] = 1'b1;
                if ($urandom_range(63) == 0) req_s[k] = '1;
            end
        end
        if (mode == 2) dat_s = {$urandom, $urandom, $urandom};
    endtask

    task automatic step();
        logic [OUT_W-1:0] act, exp;
        bit found;
        int g, c;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            act = actual_out(k);
            exp = expect_out(k);
            vectors++;
            if (act !== exp) begin
                miscompares++;
                $display("FAIL outputs dut%0d cyc=%0d got=%h want=%h (ack,so,so_valid,frame_start,ch_id,busy)",
                         k, cyc, act, exp);
            end
            ack_now[k] = act[OUT_W-1 -: NCH];
            observe(k, act);
        end
        stim();
        if (release_now) begin
            rst_n = 1'b1;
            release_now = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (rst_n && model_idle(k) && req_s[k] != '0) begin
                found = 1'b0; g = 0;
                for (int i = 0; i < NCH; i++) begin
                    c = (m_ptr[k] + i) % NCH;
                    if (!found && req_s[k][c]) begin g = c; found = 1'b1; end
                end
                m_has[k] = 1'b1;
                m_start[k] = cyc + 1;
                m_gch[k] = g;
                m_word[k] = dat_s[g*DW +: DW];
                m_ptr[k] = (g + 1) % NCH;
            end
        end
        cyc++;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic wait_acks0(int n, int budget);
        int t;
        t = 0;
        while (acks0.size() < n && t < budget) begin
            step();
            t++;
        end
        chk("ack_wait_dut0", int'(acks0.size() >= n), 1);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        model_reset();
        req_s[0] = '0; req_s[1] = '0;
        run(2);
    endtask

    int rel_cyc;

    initial begin
        req_s[0] = '0; req_s[1] = '0; dat_s = '0;
        clear_obs();
        #1 rst_n = 1'b0;
        model_reset();
        run(3);
        chk("reset_outputs_dut0", int'(actual_out(0)), 0);
        chk("reset_outputs_dut1", int'(actual_out(1)), 0);

        // Single request on channel 2.
        dat_s = {$urandom, $urandom, $urandom};
        dat_s[2*DW +: DW] = 16'hA5C3;
        req_s[0] = 6'b000100; req_s[1] = 6'b000100;
        mode = 0;
        clear_obs();
        rel_cyc = cyc;
        release_now = 1'b1;
        run(40);
        chk("single_ack_count", acks0.size(), 1);
        chk("single_ack_ch", qa(acks0, 0), 2);
        chk("single_word", qa(words0, 0), 16'hA5C3);
        chk("single_fs_count", fs0.size(), 1);
        chk("single_fs_cycle", qa(fs0, 0), rel_cyc + 1);
        chk("single_busy_cycles_gap2", busy_cnt[0], 18);
        chk("single_busy_cycles_gap0", busy_cnt[1], 16);
        chk("single_ch_id", int'(if0.ch_id), 2);
        chk("single_word_gap0", qa(words1, 0), 16'hA5C3);

        // All six held: strict rotation, fixed word period.
        hold_reset();
        dat_s = {16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_s[0] = '1; req_s[1] = '1;
        mode = 1;
        clear_obs();
        release_now = 1'b1;
        wait_acks0(7, 200);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("rr_order_dut0_%0d", i), qa(acks0, i), i % NCH);
            chk($sformatf("rr_order_dut1_%0d", i), qa(acks1, i), i % NCH);
        end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("fs_spacing_gap2_%0d", i), qa(fs0, i + 1) - qa(fs0, i), 19);
            chk($sformatf("fs_spacing_gap0_%0d", i), qa(fs1, i + 1) - qa(fs1, i), 17);
            chk($sformatf("rr_word_%0d", i), qa(words0, i), 16'h1111 * (i + 1));
        end

        // Pointer wrap: serve ch5, then ch0 wins over ch5.
        hold_reset();
        dat_s = {$urandom, $urandom, $urandom};
        req_s[0] = 6'b100000; req_s[1] = 6'b100000;
        mode = 0;
        clear_obs();
        release_now = 1'b1;
        wait_acks0(1, 40);
        req_s[0] = 6'b100001; req_s[1] = 6'b100001;
        run(60);
        chk("wrap_first", qa(acks0, 0), 5);
        chk("wrap_second", qa(acks0, 1), 0);
        chk("wrap_third", qa(acks0, 2), 5);
        chk("wrap_second_gap0", qa(acks1, 1), 0);

        // Asynchronous reset during bit 7, then restart on channel 1.
        hold_reset();
        dat_s = {$urandom, $urandom, $urandom};
        dat_s[1*DW +: DW] = 16'hBEEF;
        req_s[0] = 6'b000010; req_s[1] = 6'b000010;
        mode = 0;
        clear_obs();
        release_now = 1'b1;
        wait_acks0(1, 40);
        run(6);
        chk("midword_so_valid_before", int'(if0.so_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clear_dut0", int'(actual_out(0)), 0);
        chk("async_clear_dut1", int'(actual_out(1)), 0);
        model_reset();
        req_s[0] = 6'b000010; req_s[1] = 6'b000010;
        run(2);
        clear_obs();
        release_now = 1'b1;
        run(40);
        chk("restart_ack_ch", qa(acks0, 0), 1);
        chk("restart_ack_count", acks0.size(), 1);
        chk("restart_word", qa(words0, 0), 16'hBEEF);
        chk("restart_word_gap0", qa(words1, 0), 16'hBEEF);

        // Quiet bus.
        hold_reset();
        mode = 0;
        clear_obs();
        release_now = 1'b1;
        run(100);
        chk("idle_activity_dut0", nz_cnt[0], 0);
        chk("idle_activity_dut1", nz_cnt[1], 0);

        // Randomized requests and data against the model.
        mode = 2;
        clear_obs();
        run(3000);
        chk("random_traffic_seen", int'(acks0.size() > 100), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
